// File: rtl/ranperm_pkg.sv
// ============================================================================
//  Module      : ranperm_pkg
//  Description : Shared types, constants and the LFSR step function for the
//                random-permutation generator family.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ranperm_pkg;

  // Controller phases: fill the array, shuffle it, then stream it out.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    SHUFFLE = 2'd2,
    STREAM  = 2'd3
  } state_e;

  // Right-shifting Galois toggle mask for x^32+x^22+x^2+x+1
  // (term x^e maps onto bit e-1).
  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEF_SEED = 32'h0000_ABCD;

  // One Galois step: shift right, fold the polynomial back in on a set LSB.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ranperm_stream_if.sv
// ============================================================================
//  Module      : ranperm_stream_if
//  Description : Valid/ready index stream carrying one permutation element
//                per beat, with a last-beat marker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ranperm_stream_if #(
  parameter int IDX_W = 7
) ();

  logic [IDX_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/ranperm_lfsr.sv
// ============================================================================
//  Module      : ranperm_lfsr
//  Description : 32-bit Galois LFSR with synchronous load and advance enables.
//                Load wins over advance; the register holds otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ranperm_lfsr
  import ranperm_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = LFSR_DEF_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        adv_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // Next value: explicit load, one polynomial step, or hold.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = load_val_i;
    end else if (adv_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  // State register, reset to the configured seed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

`default_nettype wire

// File: rtl/ranperm_stream.sv
// ============================================================================
//  Module      : ranperm_stream
//  Description : Multi-cycle Fisher-Yates permutation generator. Fills an
//                array with 0..N-1, performs one LFSR-driven swap per cycle,
//                then streams the result over a valid/ready interface.
//                Optional macro RANPERM_UNBIASED_EN selects rejection
//                sampling for the swap index instead of multiply-high.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ranperm_stream
  import ranperm_pkg::*;
#(
  parameter int          N        = 100,
  parameter logic [31:0] DEF_SEED = LFSR_DEF_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        seed_load,
  input  logic [31:0] seed,
  input  logic        start,
  output logic        busy,
  output logic        done,
  ranperm_stream_if.master out_if
);

  localparam int               IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

  state_e           state_q, state_d;
  // Shared counter: fill index in INIT, i in SHUFFLE, k in STREAM.
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] arr_q [N];

  logic [31:0]      lfsr;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic [31:0]      lfsr_seed;
  logic [IDX_W-1:0] j;
  logic             swap_en;
  logic [IDX_W-1:0] k_next;

  assign lfsr_seed = (seed == 32'h0) ? DEF_SEED : seed;
  assign k_next    = cnt_q + ONE;

  ranperm_lfsr #(
    .RESET_VAL (DEF_SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (lfsr_load),
    .load_val_i (lfsr_seed),
    .adv_i      (lfsr_adv),
    .state_o    (lfsr)
  );

`ifdef RANPERM_UNBIASED_EN
  logic [IDX_W-1:0] mask;

  // Rejection sampling: mask the LFSR to the smallest all-ones cover of i
  // and retry (no swap, i held) whenever the candidate exceeds i.
  always_comb begin
    mask = cnt_q;
    for (int b = 1; b < IDX_W; b++) begin
      mask = mask | (mask >> 1);
    end
    j       = lfsr[IDX_W-1:0] & mask;
    swap_en = (j <= cnt_q);
  end
`else
  logic [IDX_W:0]    i_plus1;
  logic [16+IDX_W:0] prod;

  // Multiply-high: j = (lfsr[15:0] * (i+1)) >> 16 always lands in 0..i.
  always_comb begin
    i_plus1 = {1'b0, cnt_q} + {{IDX_W{1'b0}}, 1'b1};
    prod    = {{(IDX_W+1){1'b0}}, lfsr[15:0]} * {16'h0, i_plus1};
    j       = prod[16 +: IDX_W];
    swap_en = 1'b1;
  end
`endif

  // Controller next-state and output-register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
        end else if (start) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      INIT: begin
        if (cnt_q == LAST) begin
          state_d = SHUFFLE;
          cnt_d   = LAST;
        end else begin
          cnt_d = k_next;
        end
      end
      SHUFFLE: begin
        lfsr_adv = 1'b1;
        if (swap_en) begin
          if (cnt_q == ONE) begin
            state_d = STREAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      STREAM: begin
        // First cycle primes the output register from the array.
        if (!valid_q) begin
          valid_d = 1'b1;
          data_d  = arr_q[cnt_q];
          last_d  = (cnt_q == LAST);
        end else if (out_if.out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d  = k_next;
            data_d = arr_q[k_next];
            last_d = (k_next == LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with asynchronous abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Permutation storage: identity fill, then one (possibly trivial) swap.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      arr_q[cnt_q] <= cnt_q;
    end else if ((state_q == SHUFFLE) && swap_en) begin
      arr_q[cnt_q] <= arr_q[j];
      arr_q[j]     <= arr_q[cnt_q];
    end
  end

  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;

endmodule

`default_nettype wire
